// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered results held until the next result.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   prem_q, prem_d;   // partial remainder, one guard bit
  logic [WIDTH-1:0] work_q, work_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Next-state, restoring iteration and result capture
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prem_d  = prem_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // Partial remainder stays below the divisor, so its top bit is zero and
    // dropping it in the shift loses nothing.
    shifted = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          if (divisor != '0) begin
            dvsr_d  = divisor;
            work_d  = dividend;
            prem_d  = '0;
            count_d = CW'(WIDTH);
            state_d = S_RUN;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (trial[WIDTH]) begin
          prem_d = shifted;
          work_d = {work_q[WIDTH-2:0], 1'b0};
        end else begin
          prem_d = trial;
          work_d = {work_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quot_d  = work_d;
          rem_d   = prem_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      prem_q  <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prem_q  <= prem_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8): expected results are
// queued when an operation is issued and compared whenever done pulses.
module tb_seq_restoring_divider;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  exp_t sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = {W{1'b1}};
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Issue one operation with a single-cycle start, then measure latency
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n;
    int unsigned bc;
    logic [W-1:0] prev_q;
    bit seen;
    @(negedge clk);
    prev_q = quotient;
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(model(a, b));
    n = 0;
    bc = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        dividend = ~a;
        divisor = b + 8'd1;
      end
      if (busy) bc++;
      if (n == 4 && b != 0) check("hold_q", 32'(quotient), 32'(prev_q));
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("latency", n, (b == 0) ? 32'd1 : 32'd9);
    check("busy_cycles", bc, (b == 0) ? 32'd0 : 32'd8);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Basic and boundary operations
    run_op(8'd100, 8'd7);
    run_op(8'd255, 8'd1);
    run_op(8'd5, 8'd9);
    run_op(8'd0, 8'd3);
    run_op(8'd255, 8'd255);
    run_op(8'd37, 8'd0);
    run_op(8'd40, 8'd8);

    // Back-to-back with start held high; second operation accepted from FIN
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    sb.push_back(model(8'd100, 8'd7));
    @(negedge clk);
    dividend = 8'd1;
    divisor = 8'd1;
    wait_done();
    dividend = 8'd200;
    divisor = 8'd3;
    sb.push_back(model(8'd200, 8'd3));
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    dividend = 8'd9;
    divisor = 8'd4;
    wait_done();
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    run_op(8'd50, 8'd6);

    // Sweep: every divisor against a strided set of dividends
    for (int b = 0; b < 256; b++) begin
      for (int a = 0; a < 256; a += 17) begin
        run_op(8'(a), 8'(b));
      end
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
